// File: rtl/as512512512_uart_txfifo.sv
// as512512512_uart_txfifo: byte FIFO feeding a UART transmitter through a start/busy handshake.
// Define UART_TXFIFO_OVF_EN to add the sticky ovf flag and its ovf_clr input.
module as512512512_uart_txfifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            wr_data,
    input  logic                  wr_en,
    input  logic                  flush,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic [7:0]            uart_din,
    output logic                  uart_start,
    input  logic                  uart_busy,
`ifdef UART_TXFIFO_OVF_EN
    output logic                  ovf,
    input  logic                  ovf_clr,
`endif
    output logic                  idle
);
    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;
    localparam logic [DEPTH_LOG2:0] ONE = (DEPTH_LOG2+1)'(1);
    state_t state, state_nx;
    logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
    logic [7:0] mem [2**DEPTH_LOG2];
    logic [1:0] wait_cnt, wait_cnt_nx;
    logic push, pop;
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign push  = wr_en && !full && !flush;
    assign idle  = empty && state == IDLE && !uart_busy;
    // wait_cnt bounds WAIT_BUSY so a start the UART never saw cannot stall the queue
    always_comb begin
        state_nx    = state;
        wait_cnt_nx = 2'd0;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                pop      = !empty && !uart_busy && !flush;
                state_nx = pop ? WAIT_BUSY : IDLE;
            end
            WAIT_BUSY: begin
                state_nx    = uart_busy ? WAIT_DONE : (wait_cnt == 2'd3 ? IDLE : WAIT_BUSY);
                wait_cnt_nx = (uart_busy || wait_cnt == 2'd3) ? 2'd0 : wait_cnt + 2'd1;
            end
            WAIT_DONE: state_nx = uart_busy ? WAIT_DONE : IDLE;
            default:   state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wait_cnt   <= 2'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            uart_start <= 1'b0;
            uart_din   <= 8'h00;
        end else begin
            state      <= state_nx;
            wait_cnt   <= wait_cnt_nx;
            wr_ptr     <= flush ? '0 : (push ? wr_ptr + ONE : wr_ptr);
            rd_ptr     <= flush ? '0 : (pop ? rd_ptr + ONE : rd_ptr);
            uart_start <= pop;
            uart_din   <= pop ? mem[rd_ptr[DEPTH_LOG2-1:0]] : uart_din;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
    end
`ifdef UART_TXFIFO_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf <= 1'b0;
        else        ovf <= (wr_en && full) ? 1'b1 : (ovf_clr ? 1'b0 : ovf);
    end
`endif
endmodule
